// File: rtl/rr_arb_wgt.sv
// Weighted round-robin arbiter: N requesters share one registered one-hot grant,
// each owner may keep the grant for up to its latched weight of consecutive cycles.
module rr_arb_wgt #(
  parameter int N  = 4,
  parameter int CW = 4,
  parameter int IW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [N-1:0]    req,
  input  logic [N*CW-1:0] weight,
  output logic [N-1:0]    gnt,
  output logic [IW-1:0]   gnt_id,
  output logic            gnt_vld
);

  logic [IW-1:0] r_ptr;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] r_lim;
  logic [N-1:0]  r_gnt;
  logic [IW-1:0] r_gnt_id;
  logic          r_gnt_vld;

  logic          w_found;
  logic [IW-1:0] w_win;
  logic [CW-1:0] w_wsel;
  logic [CW-1:0] w_eff;
  logic [CW:0]   w_cnt_inc;
  logic          w_hold;

  // Cyclic search for the first requester after the last granted index.
  always_comb begin
    w_found = 1'b0;
    w_win   = {IW{1'b0}};
    for (int k = 1; k <= N; k++) begin
      if (!w_found && req[(int'(r_ptr) + k) % N]) begin
        w_found = 1'b1;
        w_win   = IW'((int'(r_ptr) + k) % N);
      end else begin
        w_found = w_found;
      end
    end
  end

  // Burst bookkeeping: extra MSB keeps cnt+1 from wrapping before the compare.
  always_comb begin
    w_wsel    = weight[int'(w_win)*CW +: CW];
    w_eff     = (w_wsel == {CW{1'b0}}) ? {{(CW-1){1'b0}}, 1'b1} : w_wsel;
    w_cnt_inc = {1'b0, r_cnt} + {{CW{1'b0}}, 1'b1};
    w_hold    = r_gnt_vld & req[r_gnt_id] & (w_cnt_inc < {1'b0, r_lim});
  end

  // Arbitration state: disable and idle clear the grant but keep the pointer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr     <= IW'(N - 1);
      r_cnt     <= {CW{1'b0}};
      r_lim     <= {CW{1'b0}};
      r_gnt     <= {N{1'b0}};
      r_gnt_id  <= {IW{1'b0}};
      r_gnt_vld <= 1'b0;
    end else if (!en) begin
      r_cnt     <= {CW{1'b0}};
      r_gnt     <= {N{1'b0}};
      r_gnt_id  <= {IW{1'b0}};
      r_gnt_vld <= 1'b0;
    end else if (w_hold) begin
      r_cnt     <= w_cnt_inc[CW-1:0];
    end else if (w_found) begin
      r_ptr     <= w_win;
      r_cnt     <= {CW{1'b0}};
      r_lim     <= w_eff;
      r_gnt     <= {{(N-1){1'b0}}, 1'b1} << w_win;
      r_gnt_id  <= w_win;
      r_gnt_vld <= 1'b1;
    end else begin
      r_cnt     <= {CW{1'b0}};
      r_gnt     <= {N{1'b0}};
      r_gnt_id  <= {IW{1'b0}};
      r_gnt_vld <= 1'b0;
    end
  end

  assign gnt     = r_gnt;
  assign gnt_id  = r_gnt_id;
  assign gnt_vld = r_gnt_vld;

endmodule

// File: tb/tb_rr_arb_wgt.sv
// Directed bench for rr_arb_wgt (N=4, CW=4): vector table for steady-state
// sequences, hand-written sequences for drop, lone requester, enable and reset.
module tb_rr_arb_wgt;

  logic        clk;
  logic        rst;
  logic        en;
  logic [3:0]  req;
  logic [15:0] weight;
  logic [3:0]  gnt;
  logic [1:0]  gnt_id;
  logic        gnt_vld;

  int n_cmp;
  int n_err;

  rr_arb_wgt #(.N(4), .CW(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .req     (req),
    .weight  (weight),
    .gnt     (gnt),
    .gnt_id  (gnt_id),
    .gnt_vld (gnt_vld)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  req;
    logic [15:0] weight;
    logic [3:0]  exp_gnt;
    logic [1:0]  exp_id;
    logic        exp_vld;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h, required %0h", name, $time, got, exp);
    end
  endtask

  task automatic chk_out(input string name, input logic [3:0] g, input logic [1:0] id, input logic v);
    chk({name, ".gnt"}, {28'd0, gnt}, {28'd0, g});
    chk({name, ".gnt_id"}, {30'd0, gnt_id}, {30'd0, id});
    chk({name, ".gnt_vld"}, {31'd0, gnt_vld}, {31'd0, v});
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic addv(input logic [3:0] r, input logic [15:0] w, input logic [3:0] g,
                      input logic [1:0] id, input logic v);
    vec_t t;
    t.req = r; t.weight = w; t.exp_gnt = g; t.exp_id = id; t.exp_vld = v;
    vecs.push_back(t);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;

    // walking single requests, weights 1 (ptr starts at 3)
    addv(4'b0001, 16'h1111, 4'b0001, 2'd0, 1'b1);
    addv(4'b0010, 16'h1111, 4'b0010, 2'd1, 1'b1);
    addv(4'b0100, 16'h1111, 4'b0100, 2'd2, 1'b1);
    addv(4'b1000, 16'h1111, 4'b1000, 2'd3, 1'b1);
    // full load, weights 1
    addv(4'b1111, 16'h1111, 4'b0001, 2'd0, 1'b1);
    addv(4'b1111, 16'h1111, 4'b0010, 2'd1, 1'b1);
    addv(4'b1111, 16'h1111, 4'b0100, 2'd2, 1'b1);
    addv(4'b1111, 16'h1111, 4'b1000, 2'd3, 1'b1);
    addv(4'b1111, 16'h1111, 4'b0001, 2'd0, 1'b1);
    // full load, weights 0 behave as 1
    addv(4'b1111, 16'h0000, 4'b0010, 2'd1, 1'b1);
    addv(4'b1111, 16'h0000, 4'b0100, 2'd2, 1'b1);
    addv(4'b1111, 16'h0000, 4'b1000, 2'd3, 1'b1);
    addv(4'b1111, 16'h0000, 4'b0001, 2'd0, 1'b1);
    // idle: grant clears, pointer stays at 0
    addv(4'b0000, 16'h0000, 4'b0000, 2'd0, 1'b0);
    // park pointer at 3, then weighted 3/2/1/1
    addv(4'b1000, 16'h1123, 4'b1000, 2'd3, 1'b1);
    addv(4'b1111, 16'h1123, 4'b0001, 2'd0, 1'b1);
    addv(4'b1111, 16'h1123, 4'b0001, 2'd0, 1'b1);
    addv(4'b1111, 16'h1123, 4'b0001, 2'd0, 1'b1);
    addv(4'b1111, 16'h1123, 4'b0010, 2'd1, 1'b1);
    addv(4'b1111, 16'h1123, 4'b0010, 2'd1, 1'b1);
    addv(4'b1111, 16'h1123, 4'b0100, 2'd2, 1'b1);
    addv(4'b1111, 16'h1123, 4'b1000, 2'd3, 1'b1);
    addv(4'b1111, 16'h1123, 4'b0001, 2'd0, 1'b1);
    // w0 changes to 1 mid-burst: latched limit of 3 still applies
    addv(4'b1111, 16'h1121, 4'b0001, 2'd0, 1'b1);
    addv(4'b1111, 16'h1121, 4'b0001, 2'd0, 1'b1);
    addv(4'b1111, 16'h1121, 4'b0010, 2'd1, 1'b1);
    addv(4'b1111, 16'h1121, 4'b0010, 2'd1, 1'b1);
    addv(4'b1111, 16'h1121, 4'b0100, 2'd2, 1'b1);
    addv(4'b1111, 16'h1121, 4'b1000, 2'd3, 1'b1);
    addv(4'b1111, 16'h1121, 4'b0001, 2'd0, 1'b1);
    addv(4'b1111, 16'h1121, 4'b0010, 2'd1, 1'b1);

    // reset: held low 8 ns, outputs zero before and after release
    rst = 1'b0; en = 1'b1; req = 4'b0000; weight = 16'h1111;
    #8;
    chk_out("reset_hold", 4'b0000, 2'd0, 1'b0);
    rst = 1'b1;
    step();
    chk_out("reset_release", 4'b0000, 2'd0, 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      req    = vecs[i].req;
      weight = vecs[i].weight;
      step();
      chk_out($sformatf("vec%0d", i), vecs[i].exp_gnt, vecs[i].exp_id, vecs[i].exp_vld);
    end

    // early drop: owner 0 (w0=3) releases after one granted cycle
    rst = 1'b0; #1; rst = 1'b1;
    weight = 16'h1113; req = 4'b0011;
    step();
    chk_out("drop_first", 4'b0001, 2'd0, 1'b1);
    req = 4'b0010;
    step();
    chk_out("drop_rotate", 4'b0010, 2'd1, 1'b1);

    // lone requester 2 with w2=2 keeps the grant without gaps
    req = 4'b0100; weight = 16'h1213;
    for (int i = 0; i < 6; i++) begin
      step();
      chk_out($sformatf("lone%0d", i), 4'b0100, 2'd2, 1'b1);
    end

    // enable drop while gnt=0010, resume at 0100
    req = 4'b1111; weight = 16'h1111;
    step(); chk_out("en_pre0", 4'b1000, 2'd3, 1'b1);
    step(); chk_out("en_pre1", 4'b0001, 2'd0, 1'b1);
    step(); chk_out("en_pre2", 4'b0010, 2'd1, 1'b1);
    en = 1'b0;
    step(); chk_out("en_low0", 4'b0000, 2'd0, 1'b0);
    step(); chk_out("en_low1", 4'b0000, 2'd0, 1'b0);
    en = 1'b1;
    step(); chk_out("en_resume", 4'b0100, 2'd2, 1'b1);

    // asynchronous reset inside a 3-cycle burst of requester 3
    weight = 16'h3111;
    step(); chk_out("ar_burst", 4'b1000, 2'd3, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    chk_out("ar_immediate", 4'b0000, 2'd0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    step(); chk_out("ar_first", 4'b0001, 2'd0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout at %0t: got no finish, required finish", $time);
    $fatal(1);
  end

endmodule
